// File: rtl/ysyx_22050598_wb_arbiter_pkg.sv
// Shared widths and requester encoding for the writeback arbiter and its scoreboard.
package ysyx_22050598_wb_arbiter_pkg;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_LEN   = 64;
    localparam int SB_CNT_W      = 2;
    localparam int NUM_REGS      = 1 << RF_ADDR_WIDTH;

    localparam logic [SB_CNT_W-1:0] SB_CNT_MAX = '1;

    typedef enum logic {
        WB_SRC_EXU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/ysyx_22050598_wb_scoreboard.sv
// Per-register pending-write counters: bumped on issue, drained when a write retires.
module ysyx_22050598_wb_scoreboard
    import ysyx_22050598_wb_arbiter_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inc_en,
    input  logic [RF_ADDR_WIDTH-1:0] inc_idx,
    input  logic                     dec_en,
    input  logic [RF_ADDR_WIDTH-1:0] dec_idx,
    input  logic [RF_ADDR_WIDTH-1:0] rs1_idx,
    input  logic [RF_ADDR_WIDTH-1:0] rs2_idx,
    input  logic [RF_ADDR_WIDTH-1:0] rd_idx,
    output logic [SB_CNT_W-1:0]      rs1_cnt,
    output logic [SB_CNT_W-1:0]      rs2_cnt,
    output logic [SB_CNT_W-1:0]      rd_cnt,
    output logic                     underflow
);

    logic [SB_CNT_W-1:0] cnt_q [NUM_REGS];
    logic [SB_CNT_W-1:0] cnt_d [NUM_REGS];
    logic                underflow_q, underflow_d;
    logic                same_reg;

    // NOTE: every variable gets its default before any branch, so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d       = cnt_q;
        underflow_d = underflow_q;
        same_reg    = inc_en && dec_en && (inc_idx == dec_idx);

        if (inc_en && !same_reg) begin
            cnt_d[inc_idx] = cnt_q[inc_idx] + 1'b1;
        end
        if (dec_en && !same_reg) begin
            if (cnt_q[dec_idx] == '0) begin
                underflow_d = 1'b1;
            end else begin
                cnt_d[dec_idx] = cnt_q[dec_idx] - 1'b1;
            end
        end
    end

    // NOTE: the counter array is reset explicitly; a stale count after reset would block issue forever.
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
            underflow_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            underflow_q <= underflow_d;
        end
    end

    assign rs1_cnt   = cnt_q[rs1_idx];
    assign rs2_cnt   = cnt_q[rs2_idx];
    assign rd_cnt    = cnt_q[rd_idx];
    assign underflow = underflow_q;

endmodule

// File: rtl/ysyx_22050598_wb_arbiter.sv
// Round-robin sharing of the regfile write port between EXU and LSU, with a RAW/WAW issue interlock.
module ysyx_22050598_wb_arbiter
    import ysyx_22050598_wb_arbiter_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iss_valid,
    output logic                     iss_ready,
    input  logic                     iss_rd_wen,
    input  logic [RF_ADDR_WIDTH-1:0] iss_rd_idx,
    input  logic [RF_ADDR_WIDTH-1:0] iss_rs1_idx,
    input  logic [RF_ADDR_WIDTH-1:0] iss_rs2_idx,
    input  logic                     exu_valid,
    output logic                     exu_ready,
    input  logic [RF_ADDR_WIDTH-1:0] exu_rd_idx,
    input  logic [RF_DATA_LEN-1:0]   exu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [RF_ADDR_WIDTH-1:0] lsu_rd_idx,
    input  logic [RF_DATA_LEN-1:0]   lsu_data,
    output logic                     rf_write_en,
    output logic [RF_ADDR_WIDTH-1:0] rf_write_rd_idx,
    output logic [RF_DATA_LEN-1:0]   rf_write_rd_data,
    output logic                     sb_underflow
);

    wb_src_e                  rr_ptr_q, rr_ptr_d;
    logic                     grant_exu, grant_lsu;
    logic                     wen_q, wen_d;
    logic [RF_ADDR_WIDTH-1:0] widx_q, widx_d;
    logic [RF_DATA_LEN-1:0]   wdata_q, wdata_d;
    logic [SB_CNT_W-1:0]      rs1_cnt, rs2_cnt, rd_cnt;
    logic                     sb_inc;

    always_comb begin
        grant_exu = exu_valid && (!lsu_valid || rr_ptr_q == WB_SRC_EXU);
        grant_lsu = lsu_valid && (!exu_valid || rr_ptr_q == WB_SRC_LSU);

        // The pointer only moves when both sides competed, handing priority to the loser.
        rr_ptr_d = rr_ptr_q;
        if (exu_valid && lsu_valid) begin
            rr_ptr_d = grant_lsu ? WB_SRC_EXU : WB_SRC_LSU;
        end

        // Writes to x0 consume a grant but never reach the regfile or the scoreboard.
        wen_d   = 1'b0;
        widx_d  = widx_q;
        wdata_d = wdata_q;
        if (grant_lsu) begin
            wen_d   = (lsu_rd_idx != '0);
            widx_d  = lsu_rd_idx;
            wdata_d = lsu_data;
        end else if (grant_exu) begin
            wen_d   = (exu_rd_idx != '0);
            widx_d  = exu_rd_idx;
            wdata_d = exu_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= WB_SRC_LSU;
            wen_q    <= 1'b0;
            widx_q   <= '0;
            wdata_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wen_q    <= wen_d;
            widx_q   <= widx_d;
            wdata_q  <= wdata_d;
        end
    end

    // Hazards are judged on committed counts only; a write still in the register does not bypass.
    assign iss_ready = !((rs1_cnt != '0) && (iss_rs1_idx != '0))
                    && !((rs2_cnt != '0) && (iss_rs2_idx != '0))
                    && !(iss_rd_wen && (rd_cnt == SB_CNT_MAX));
    assign sb_inc    = iss_valid && iss_ready && iss_rd_wen && (iss_rd_idx != '0);

    ysyx_22050598_wb_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .inc_en    (sb_inc),
        .inc_idx   (iss_rd_idx),
        .dec_en    (wen_q),
        .dec_idx   (widx_q),
        .rs1_idx   (iss_rs1_idx),
        .rs2_idx   (iss_rs2_idx),
        .rd_idx    (iss_rd_idx),
        .rs1_cnt   (rs1_cnt),
        .rs2_cnt   (rs2_cnt),
        .rd_cnt    (rd_cnt),
        .underflow (sb_underflow)
    );

    assign exu_ready        = grant_exu;
    assign lsu_ready        = grant_lsu;
    assign rf_write_en      = wen_q;
    assign rf_write_rd_idx  = widx_q;
    assign rf_write_rd_data = wdata_q;

endmodule
